// File: rtl/mrv1_idecode_sb_if.sv
// Decode / issue / retire / flush bundle of the MRV1 scoreboard. Signal suffixes
// are named from the scoreboard's point of view (slave modport).
interface mrv1_idecode_sb_if #(
    parameter int NUM_THREADS_P   = 4,
    parameter int RF_ADDR_WIDTH_P = 5,
    parameter int NUM_RS_P        = 2,
    parameter int PAYLOAD_WIDTH_P = 64
);
    localparam int TWID_W = (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1;

    logic                                dec_vld_i;
    logic                                dec_rdy_o;
    logic [TWID_W-1:0]                   dec_twid_i;
    logic [NUM_RS_P-1:0]                 dec_rs_vld_i;
    logic [NUM_RS_P*RF_ADDR_WIDTH_P-1:0] dec_rs_addr_i;
    logic                                dec_rd_vld_i;
    logic [RF_ADDR_WIDTH_P-1:0]          dec_rd_addr_i;
    logic [PAYLOAD_WIDTH_P-1:0]          dec_payload_i;

    logic                                issue_vld_o;
    logic                                issue_rdy_i;
    logic [TWID_W-1:0]                   issue_twid_o;
    logic                                issue_rd_vld_o;
    logic [RF_ADDR_WIDTH_P-1:0]          issue_rd_addr_o;
    logic [PAYLOAD_WIDTH_P-1:0]          issue_payload_o;

    logic                                retire_vld_i;
    logic [TWID_W-1:0]                   retire_twid_i;
    logic [RF_ADDR_WIDTH_P-1:0]          retire_rd_addr_i;

    logic                                flush_vld_i;
    logic [TWID_W-1:0]                   flush_twid_i;

    logic [NUM_RS_P-1:0]                 rs_conflict_o;
    logic [NUM_THREADS_P-1:0]            thread_busy_o;
    logic                                sb_err_o;

    modport slave (
        input  dec_vld_i, dec_twid_i, dec_rs_vld_i, dec_rs_addr_i,
               dec_rd_vld_i, dec_rd_addr_i, dec_payload_i,
               issue_rdy_i, retire_vld_i, retire_twid_i, retire_rd_addr_i,
               flush_vld_i, flush_twid_i,
        output dec_rdy_o, issue_vld_o, issue_twid_o, issue_rd_vld_o,
               issue_rd_addr_o, issue_payload_o,
               rs_conflict_o, thread_busy_o, sb_err_o
    );

    modport master (
        output dec_vld_i, dec_twid_i, dec_rs_vld_i, dec_rs_addr_i,
               dec_rd_vld_i, dec_rd_addr_i, dec_payload_i,
               issue_rdy_i, retire_vld_i, retire_twid_i, retire_rd_addr_i,
               flush_vld_i, flush_twid_i,
        input  dec_rdy_o, issue_vld_o, issue_twid_o, issue_rd_vld_o,
               issue_rd_addr_o, issue_payload_o,
               rs_conflict_o, thread_busy_o, sb_err_o
    );
endinterface

// File: rtl/mrv1_idecode_sb.sv
// Per-thread register scoreboard with saturating outstanding-write counters and a
// single-entry decode-to-issue output register with per-thread flush.
module mrv1_idecode_sb #(
    parameter int NUM_THREADS_P   = 4,
    parameter int RF_ADDR_WIDTH_P = 5,
    parameter int NUM_RS_P        = 2,
    parameter int CNT_WIDTH_P     = 2,
    parameter int PAYLOAD_WIDTH_P = 64
) (
    input logic              clk_i,
    input logic              rst_i,
    mrv1_idecode_sb_if.slave sb
);
    localparam int TWID_W   = (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1;
    localparam int NUM_REGS = 1 << RF_ADDR_WIDTH_P;
    localparam logic [CNT_WIDTH_P-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH_P-1:0]     cnt_q [NUM_THREADS_P][NUM_REGS];
    logic [CNT_WIDTH_P-1:0]     cnt_d [NUM_THREADS_P][NUM_REGS];
    logic                       out_vld_q, out_vld_d;
    logic [TWID_W-1:0]          twid_q, twid_d;
    logic                       rd_vld_q, rd_vld_d;
    logic [RF_ADDR_WIDTH_P-1:0] rd_addr_q, rd_addr_d;
    logic [PAYLOAD_WIDTH_P-1:0] payload_q, payload_d;
    logic                       err_q, err_d;

    logic [NUM_RS_P-1:0]        rs_conflict;
    logic                       sat;
    logic                       space;
    logic                       fl_hit;
    logic                       accept;
    logic                       issue_vld;
    logic [NUM_THREADS_P-1:0]   busy;

    // Hazards look only at registered counts; a same-cycle retire does not bypass.
    always_comb begin
        rs_conflict = '0;
        for (int i = 0; i < NUM_RS_P; i++) begin
            if (sb.dec_vld_i && sb.dec_rs_vld_i[i] &&
                (sb.dec_rs_addr_i[i*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P] != '0) &&
                (cnt_q[sb.dec_twid_i][sb.dec_rs_addr_i[i*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P]] != '0))
                rs_conflict[i] = 1'b1;
        end
        sat = sb.dec_rd_vld_i && (sb.dec_rd_addr_i != '0) &&
              (cnt_q[sb.dec_twid_i][sb.dec_rd_addr_i] == CNT_MAX);
        space     = !out_vld_q || sb.issue_rdy_i;
        fl_hit    = sb.flush_vld_i && (sb.flush_twid_i == sb.dec_twid_i);
        accept    = sb.dec_vld_i && !(|rs_conflict) && !sat && space && !fl_hit;
        issue_vld = out_vld_q && !(sb.flush_vld_i && (sb.flush_twid_i == twid_q));
    end

    // Flush of a thread wins over any same-cycle increment or retire on it.
    always_comb begin
        cnt_d = cnt_q;
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                logic inc_hit;
                logic dec_hit;
                inc_hit = accept && sb.dec_rd_vld_i &&
                          (sb.dec_twid_i == TWID_W'(t)) &&
                          (sb.dec_rd_addr_i == RF_ADDR_WIDTH_P'(r));
                dec_hit = sb.retire_vld_i &&
                          (sb.retire_twid_i == TWID_W'(t)) &&
                          (sb.retire_rd_addr_i == RF_ADDR_WIDTH_P'(r)) &&
                          (cnt_q[t][r] != '0);
                if (sb.flush_vld_i && (sb.flush_twid_i == TWID_W'(t)))
                    cnt_d[t][r] = '0;
                else if (inc_hit && !dec_hit)
                    cnt_d[t][r] = cnt_q[t][r] + CNT_WIDTH_P'(1);
                else if (dec_hit && !inc_hit)
                    cnt_d[t][r] = cnt_q[t][r] - CNT_WIDTH_P'(1);
            end
        end
        err_d = sb.retire_vld_i && (sb.retire_rd_addr_i != '0) &&
                (cnt_q[sb.retire_twid_i][sb.retire_rd_addr_i] == '0) &&
                !(sb.flush_vld_i && (sb.flush_twid_i == sb.retire_twid_i));
    end

    always_comb begin
        out_vld_d = out_vld_q;
        twid_d    = twid_q;
        rd_vld_d  = rd_vld_q;
        rd_addr_d = rd_addr_q;
        payload_d = payload_q;
        if (accept) begin
            out_vld_d = 1'b1;
            twid_d    = sb.dec_twid_i;
            rd_vld_d  = sb.dec_rd_vld_i;
            rd_addr_d = sb.dec_rd_addr_i;
            payload_d = sb.dec_payload_i;
        end else if (out_vld_q && !issue_vld) begin
            out_vld_d = 1'b0;
        end else if (issue_vld && sb.issue_rdy_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_comb begin
        busy = '0;
        for (int t = 0; t < NUM_THREADS_P; t++)
            for (int r = 0; r < NUM_REGS; r++)
                busy[t] = busy[t] | (cnt_q[t][r] != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int t = 0; t < NUM_THREADS_P; t++)
                for (int r = 0; r < NUM_REGS; r++)
                    cnt_q[t][r] <= '0;
            out_vld_q <= 1'b0;
            twid_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            payload_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            twid_q    <= twid_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            payload_q <= payload_d;
            err_q     <= err_d;
        end
    end

    assign sb.dec_rdy_o       = accept;
    assign sb.rs_conflict_o   = rs_conflict;
    assign sb.issue_vld_o     = issue_vld;
    assign sb.issue_twid_o    = twid_q;
    assign sb.issue_rd_vld_o  = rd_vld_q;
    assign sb.issue_rd_addr_o = rd_addr_q;
    assign sb.issue_payload_o = payload_q;
    assign sb.thread_busy_o   = busy;
    assign sb.sb_err_o        = err_q;
endmodule

// File: tb/tb_mrv1_idecode_sb.sv
// Directed bench for mrv1_idecode_sb: hazards, saturation, backpressure,
// flush, retire errors and mid-stall reset, all with hand-computed expectations.
module tb_mrv1_idecode_sb;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mrv1_idecode_sb_if bus ();

    mrv1_idecode_sb dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .sb    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic vld, input logic [1:0] tw, input logic [1:0] rsv,
                           input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic rdv, input logic [4:0] rd, input logic [63:0] pl);
        bus.dec_vld_i     = vld;
        bus.dec_twid_i    = tw;
        bus.dec_rs_vld_i  = rsv;
        bus.dec_rs_addr_i = {rs1, rs0};
        bus.dec_rd_vld_i  = rdv;
        bus.dec_rd_addr_i = rd;
        bus.dec_payload_i = pl;
    endtask

    task automatic set_ret(input logic vld, input logic [1:0] tw, input logic [4:0] rd);
        bus.retire_vld_i     = vld;
        bus.retire_twid_i    = tw;
        bus.retire_rd_addr_i = rd;
    endtask

    task automatic set_flush(input logic vld, input logic [1:0] tw);
        bus.flush_vld_i  = vld;
        bus.flush_twid_i = tw;
    endtask

    initial begin
        rst_n = 1'b0;
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);
        set_ret(1'b0, 2'd0, 5'd0);
        set_flush(1'b0, 2'd0);
        bus.issue_rdy_i = 1'b1;
        tick();
        tick();
        check("rst_issue_vld", 64'(bus.issue_vld_o), 64'h0);
        check("rst_busy", 64'(bus.thread_busy_o), 64'h0);
        check("rst_err", 64'(bus.sb_err_o), 64'h0);
        check("rst_payload", bus.issue_payload_o, 64'h0);
        check("rst_dec_rdy", 64'(bus.dec_rdy_o), 64'h0);
        rst_n = 1'b1;

        // RAW hazard on t0/x5, other threads unaffected
        set_dec(1'b1, 2'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 64'hA1);
        settle();
        check("t0_wr_x5_rdy", 64'(bus.dec_rdy_o), 64'h1);
        tick();
        check("t0_wr_x5_payload", bus.issue_payload_o, 64'hA1);
        check("t0_wr_x5_ivld", 64'(bus.issue_vld_o), 64'h1);
        check("t0_busy", 64'(bus.thread_busy_o), 64'h1);
        set_dec(1'b1, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 64'hA2);
        settle();
        check("raw_rs0_conf", 64'(bus.rs_conflict_o), 64'h1);
        check("raw_rs0_rdy", 64'(bus.dec_rdy_o), 64'h0);
        set_dec(1'b1, 2'd0, 2'b11, 5'd2, 5'd5, 1'b0, 5'd0, 64'hA2);
        settle();
        check("raw_rs1_conf", 64'(bus.rs_conflict_o), 64'h2);
        set_dec(1'b1, 2'd0, 2'b11, 5'd5, 5'd0, 1'b0, 5'd0, 64'hA2);
        settle();
        check("raw_x0_conf", 64'(bus.rs_conflict_o), 64'h1);
        set_dec(1'b1, 2'd1, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 64'hA2);
        settle();
        check("t1_x5_conf", 64'(bus.rs_conflict_o), 64'h0);
        check("t1_x5_rdy", 64'(bus.dec_rdy_o), 64'h1);
        set_dec(1'b1, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 64'hA2);
        set_ret(1'b1, 2'd0, 5'd5);
        settle();
        check("no_bypass_rdy", 64'(bus.dec_rdy_o), 64'h0);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        settle();
        check("post_retire_rdy", 64'(bus.dec_rdy_o), 64'h1);
        check("post_retire_busy", 64'(bus.thread_busy_o), 64'h0);
        tick();
        check("post_retire_payload", bus.issue_payload_o, 64'hA2);
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);

        // Saturation of t2/x7 at count 3
        for (int k = 0; k < 3; k++) begin
            set_dec(1'b1, 2'd2, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 64'hB0 + 64'(k));
            settle();
            check("sat_fill_rdy", 64'(bus.dec_rdy_o), 64'h1);
            tick();
        end
        check("sat_rdy", 64'(bus.dec_rdy_o), 64'h0);
        check("sat_conf", 64'(bus.rs_conflict_o), 64'h0);
        check("sat_busy", 64'(bus.thread_busy_o), 64'h4);
        set_ret(1'b1, 2'd2, 5'd7);
        settle();
        check("sat_retire_cycle_rdy", 64'(bus.dec_rdy_o), 64'h0);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        settle();
        check("sat_after_retire_rdy", 64'(bus.dec_rdy_o), 64'h1);
        tick();
        check("sat_4th_payload", bus.issue_payload_o, 64'hB2);
        check("sat_again_rdy", 64'(bus.dec_rdy_o), 64'h0);
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);
        set_flush(1'b1, 2'd2);
        tick();
        set_flush(1'b0, 2'd0);
        settle();
        check("flush_t2_busy", 64'(bus.thread_busy_o), 64'h0);

        // Backpressure then back-to-back throughput
        bus.issue_rdy_i = 1'b0;
        set_dec(1'b1, 2'd3, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'hC0DE_0000_0000_0000);
        tick();
        set_dec(1'b1, 2'd3, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'hC0DE_0000_0000_0001);
        for (int k = 0; k < 5; k++) begin
            check("bp_rdy", 64'(bus.dec_rdy_o), 64'h0);
            check("bp_payload", bus.issue_payload_o, 64'hC0DE_0000_0000_0000);
            check("bp_ivld", 64'(bus.issue_vld_o), 64'h1);
            tick();
        end
        bus.issue_rdy_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            set_dec(1'b1, 2'd3, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'hC0DE_0000_0000_0000 + 64'(k));
            settle();
            check("b2b_rdy", 64'(bus.dec_rdy_o), 64'h1);
            tick();
            check("b2b_payload", bus.issue_payload_o, 64'hC0DE_0000_0000_0000 + 64'(k));
            check("b2b_ivld", 64'(bus.issue_vld_o), 64'h1);
        end
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);
        tick();
        check("drained_ivld", 64'(bus.issue_vld_o), 64'h0);

        // Flush t1 with its entry in the output register
        set_dec(1'b1, 2'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd8, 64'hD0);
        tick();
        set_dec(1'b1, 2'd1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 64'hD1);
        tick();
        set_dec(1'b1, 2'd1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 64'hD2);
        tick();
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);
        bus.issue_rdy_i = 1'b0;
        settle();
        check("pre_flush_ivld", 64'(bus.issue_vld_o), 64'h1);
        check("pre_flush_twid", 64'(bus.issue_twid_o), 64'h1);
        check("pre_flush_rd", 64'(bus.issue_rd_addr_o), 64'h4);
        check("pre_flush_busy", 64'(bus.thread_busy_o), 64'h3);
        bus.issue_rdy_i = 1'b1;
        set_flush(1'b1, 2'd1);
        set_dec(1'b1, 2'd1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'hD3);
        settle();
        check("flush_ivld", 64'(bus.issue_vld_o), 64'h0);
        check("flush_blk_rdy", 64'(bus.dec_rdy_o), 64'h0);
        tick();
        set_flush(1'b0, 2'd0);
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);
        settle();
        check("post_flush_busy", 64'(bus.thread_busy_o), 64'h1);
        check("post_flush_ivld", 64'(bus.issue_vld_o), 64'h0);
        set_ret(1'b1, 2'd0, 5'd8);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        settle();
        check("x8_retired_busy", 64'(bus.thread_busy_o), 64'h0);

        // Retire-error pulse and its exceptions
        set_ret(1'b1, 2'd0, 5'd9);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        check("err_pulse", 64'(bus.sb_err_o), 64'h1);
        tick();
        check("err_one_cycle", 64'(bus.sb_err_o), 64'h0);
        set_ret(1'b1, 2'd0, 5'd0);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        check("err_x0", 64'(bus.sb_err_o), 64'h0);
        set_ret(1'b1, 2'd3, 5'd9);
        set_flush(1'b1, 2'd3);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        set_flush(1'b0, 2'd0);
        check("err_flushed", 64'(bus.sb_err_o), 64'h0);
        set_dec(1'b1, 2'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd6, 64'hE0);
        tick();
        set_ret(1'b1, 2'd0, 5'd6);
        settle();
        check("incdec_rdy", 64'(bus.dec_rdy_o), 64'h1);
        tick();
        set_dec(1'b0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0);
        set_ret(1'b0, 2'd0, 5'd0);
        settle();
        check("incdec_busy", 64'(bus.thread_busy_o), 64'h1);
        set_ret(1'b1, 2'd0, 5'd6);
        tick();
        set_ret(1'b0, 2'd0, 5'd0);
        check("incdec_cnt_was_1", 64'(bus.thread_busy_o), 64'h0);
        check("incdec_no_err", 64'(bus.sb_err_o), 64'h0);

        // Reset in the middle of a stall
        set_dec(1'b1, 2'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 64'hF0);
        tick();
        bus.issue_rdy_i = 1'b0;
        set_dec(1'b1, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 64'hF1);
        settle();
        check("stall_rdy", 64'(bus.dec_rdy_o), 64'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("mid_rst_ivld", 64'(bus.issue_vld_o), 64'h0);
        check("mid_rst_payload", bus.issue_payload_o, 64'h0);
        check("mid_rst_rdvld", 64'(bus.issue_rd_vld_o), 64'h0);
        check("mid_rst_rdaddr", 64'(bus.issue_rd_addr_o), 64'h0);
        check("mid_rst_twid", 64'(bus.issue_twid_o), 64'h0);
        check("mid_rst_busy", 64'(bus.thread_busy_o), 64'h0);
        check("mid_rst_err", 64'(bus.sb_err_o), 64'h0);
        check("mid_rst_conf", 64'(bus.rs_conflict_o), 64'h0);
        check("mid_rst_rdy", 64'(bus.dec_rdy_o), 64'h1);
        set_dec(1'b0, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 64'hF1);
        settle();
        check("mid_rst_rdy_idle", 64'(bus.dec_rdy_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
